// File: rtl/bscan_master.sv
// bscan_master: boundary-scan chain master.
//
// Runs one operation per accepted start against a CHAIN_LEN-cell scan chain:
//   op 00 SAMPLE : CAPTURE -> SHIFT(CHAIN_LEN) -> FINISH
//   op 01 EXTEST : CAPTURE -> SHIFT(CHAIN_LEN) -> UPDATE -> FINISH
//   op 10 BYPASS : BYPASS(CHAIN_LEN+1) -> FINISH
//   op 11        : reserved, one-cycle err pulse, no operation
//
// Ports:
//   tck, rst_n        clock (rising edge) and asynchronous active-low reset
//   start, op         request and operation select
//   pattern           data to shift in, bit i ends up in cell i (cell 0 at tdi)
//   tdo               serial return from the chain
//   tdi               serial data to the chain
//   shift_dr, up_enable, mode, sel, bp_shift   target control lines
//   busy, done, err   status (done and err are one-cycle pulses)
//   capture           shifted-out data, bit i = cell i value before shifting
//   dbg_state         current FSM state, for observation only
//
// Handshake: start is a one-cycle request. It is accepted only while the
// FSM is in IDLE; a start seen in any other state is dropped. op and
// pattern are latched on the accepting edge and ignored afterwards.
//
// All outputs are registers. Their next values are decoded from the next
// state, so each output register is aligned with the state register and
// the target samples it on the following rising edge.
module bscan_master #(
    parameter int CHAIN_LEN = 6
) (
    input  logic                 tck,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic                 tdo,
    output logic                 tdi,
    output logic                 shift_dr,
    output logic                 up_enable,
    output logic                 mode,
    output logic                 sel,
    output logic                 bp_shift,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] capture,
    output logic                 err,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_SHIFT   = 3'd2,
        S_UPDATE  = 3'd3,
        S_BYPASS  = 3'd4,
        S_FINISH  = 3'd5
    } state_e;

    localparam int             CW        = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0]  CNT_N     = CW'(CHAIN_LEN);
    localparam logic [1:0]     OP_EXTEST = 2'b01;
    localparam logic [1:0]     OP_BYPASS = 2'b10;
    localparam logic [1:0]     OP_RSVD   = 2'b11;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [1:0]             op_q, op_d;
    logic [CHAIN_LEN-1:0]   pat_q, pat_d;
    logic [CHAIN_LEN-1:0]   capture_q, capture_d;
    logic [CHAIN_LEN-1:0]   pat_shl;
    logic tdi_q, tdi_d;
    logic shift_dr_q, shift_dr_d;
    logic up_enable_q, up_enable_d;
    logic mode_q, mode_d;
    logic sel_q, sel_d;
    logic bp_shift_q, bp_shift_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            pat_q       <= '0;
            capture_q   <= '0;
            tdi_q       <= 1'b0;
            shift_dr_q  <= 1'b0;
            up_enable_q <= 1'b0;
            mode_q      <= 1'b0;
            sel_q       <= 1'b0;
            bp_shift_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            pat_q       <= pat_d;
            capture_q   <= capture_d;
            tdi_q       <= tdi_d;
            shift_dr_q  <= shift_dr_d;
            up_enable_q <= up_enable_d;
            mode_q      <= mode_d;
            sel_q       <= sel_d;
            bp_shift_q  <= bp_shift_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic and capture shift register.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        pat_d     = pat_q;
        capture_d = capture_q;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        op_d    = op;
                        pat_d   = pattern;
                        cnt_d   = '0;
                        state_d = (op == OP_BYPASS) ? S_BYPASS : S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                // The cell nearest tdo comes out first, so shifting in at
                // the LSB leaves it in the MSB after CHAIN_LEN samples.
                capture_d = {capture_q[CHAIN_LEN-2:0], tdo};
                if (cnt_q == CNT_LAST) begin
                    state_d = (op_q == OP_EXTEST) ? S_UPDATE : S_FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_UPDATE: begin
                state_d = S_FINISH;
            end
            S_BYPASS: begin
                // The bypass register adds one cycle of latency: tdo in
                // cycle 0 is stale and is dropped.
                if (cnt_q != '0) begin
                    capture_d = {capture_q[CHAIN_LEN-2:0], tdo};
                end
                if (cnt_q == CNT_N) begin
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, registered above.
    always_comb begin
        pat_shl     = pat_d << cnt_d;
        tdi_d       = ((state_d == S_SHIFT) ||
                       ((state_d == S_BYPASS) && (cnt_d != CNT_N))) && pat_shl[CHAIN_LEN-1];
        shift_dr_d  = (state_d == S_SHIFT);
        up_enable_d = (state_d == S_UPDATE);
        sel_d       = (state_d == S_BYPASS);
        bp_shift_d  = (state_d == S_BYPASS);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_FINISH);
        // mode follows the latched op for the whole operation, FINISH included.
        mode_d      = (state_d != S_IDLE) && (op_d == OP_EXTEST);
    end

    assign tdi       = tdi_q;
    assign shift_dr  = shift_dr_q;
    assign up_enable = up_enable_q;
    assign mode      = mode_q;
    assign sel       = sel_q;
    assign bp_shift  = bp_shift_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign capture   = capture_q;
    assign dbg_state = state_q;

endmodule
